// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with overflow and leading-zero blanking
module bin_to_bcd_seq #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int BW = 4*DIGITS;
  localparam int MAX_VAL = 10**DIGITS - 1;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIN_W-1);
  localparam logic [BW-1:0] RST_BCD = BLANK_LZ ? ({BW{1'b1}} << 4) : '0;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] acc, adj, fmt;
  logic [BIN_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic ovf_pend;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && start) ? SHIFT :
              (state_q == SHIFT && cnt == LAST) ? FINISH :
              (state_q == FINISH) ? IDLE : state_q;
  end
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // Blank zeros from the top down until the first non-zero digit; digit 0 always shows.
  always_comb begin
    logic lead;
    fmt = acc;
    lead = BLANK_LZ;
    for (int i = DIGITS-1; i > 0; i--) begin
      if (lead && acc[4*i +: 4] == 4'd0) fmt[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd_out  <= RST_BCD;
      acc      <= '0;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= (state_q == FINISH);
      if (state_q == IDLE && start) begin
        sr       <= bin_in;
        acc      <= '0;
        cnt      <= '0;
        ovf_pend <= int'(bin_in) > MAX_VAL;
        busy     <= 1'b1;
      end
      if (state_q == SHIFT) begin
        {acc, sr} <= {adj, sr} << 1;
        cnt       <= cnt + 1'b1;
      end
      if (state_q == FINISH) begin
        busy    <= 1'b0;
        ovf     <= ovf_pend;
        bcd_out <= ovf_pend ? '1 : fmt;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized scoreboard bench for bin_to_bcd_seq, blanking and non-blanking instances
module tb_bin_to_bcd_seq;
  localparam int BIN_W = 14;
  typedef struct { logic [16:0] r; int due; } exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [BIN_W-1:0] bin_in = '0;
  logic busy, done, ovf, busy0, done0, ovf0;
  logic [15:0] bcd_out, bcd0;
  exp_t q[$], q0[$];
  int cyc = 0, pass = 0, total = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf));
  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .ovf(ovf0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model(int v, bit blank);
    logic [15:0] r;
    bit lead;
    int d;
    lead = blank;
    r = '0;
    if (v > 9999) return {1'b1, 16'hFFFF};
    for (int i = 3; i >= 0; i--) begin
      d = (v / (10**i)) % 10;
      r[4*i +: 4] = (lead && d == 0 && i > 0) ? 4'hF : 4'(d);
      if (d != 0) lead = 0;
    end
    return {1'b0, r};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive at a negedge; expectation queued only when the DUT is idle and will take it.
  task automatic send(int v);
    start = 1;
    bin_in = BIN_W'(v);
    if (!busy) begin
      q.push_back('{model(v, 1), cyc + BIN_W + 2});
      q0.push_back('{model(v, 0), cyc + BIN_W + 2});
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q.size() > 0 || q0.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    chk("drain_timeout", q.size() + q0.size(), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("done_seen", {31'd0, done}, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("busy_in_done", {31'd0, busy}, 0);
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("bcd_out", {16'd0, bcd_out}, {16'd0, e.r[15:0]});
        chk("ovf", {31'd0, ovf}, {31'd0, e.r[16]});
        chk("latency", cyc, e.due);
      end
    end
    if (done0) begin
      if (q0.size() == 0) chk("spurious_done0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("bcd_out_nolz", {16'd0, bcd0}, {16'd0, e.r[15:0]});
        chk("ovf_nolz", {31'd0, ovf0}, {31'd0, e.r[16]});
        chk("latency_nolz", cyc, e.due);
      end
    end
  end

  task automatic chk_reset();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_bcd", {16'd0, bcd_out}, 32'hFFF0);
    chk("rst_bcd_nolz", {16'd0, bcd0}, 32'h0000);
  endtask

  initial begin
    int dirs[7] = '{1234, 9999, 10000, 16383, 7, 1005, 0};
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk_reset();
    send(1234);
    chk("busy_rise", {31'd0, busy}, 1);
    repeat (14) @(negedge clk);
    chk("busy_hold", {31'd0, busy}, 1);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 0);
    drain();
    foreach (dirs[i]) begin
      send(dirs[i]);
      drain();
    end
    send(500);
    send(42);
    wait_done();
    send(42);
    drain();
    send(3579);
    repeat (5) @(negedge clk);
    rst_n = 0;
    q.delete();
    q0.delete();
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk_reset();
    send(81);
    drain();
    for (int n = 0; n < 60; n++) begin
      send(($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
